// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port unified word memory
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of data-first priority.
module mem_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] DATA_BASE  = 32'h1001_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [DATA_WIDTH-1:0]    i_addr,
    output logic [DATA_WIDTH-1:0]    i_rdata,
    output logic                     i_ready,
    output logic                     i_err,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [DATA_WIDTH-1:0]    d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_ready,
    output logic                     d_err,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int                    AW           = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] REGION_BYTES = DATA_WIDTH'(2 * DEPTH);
    localparam logic [AW-1:0]         HALF         = AW'(DEPTH / 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} gnt_t;

    state_t                state_q, state_d;
    gnt_t                  gnt_q, gnt_d, gnt_sel;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    // Offsets wrap modulo 2^DATA_WIDTH, so an address below its base lands far out of range.
    logic [DATA_WIDTH-1:0] i_off, d_off;
    logic                  i_fault, d_fault, acc_fault;
    logic [AW-1:0]         i_idx, d_idx;

    assign i_off   = i_addr - TEXT_BASE;
    assign d_off   = d_addr - DATA_BASE;
    assign i_fault = (i_addr[1:0] != 2'b00) || (i_off >= REGION_BYTES);
    assign d_fault = (d_addr[1:0] != 2'b00) || (d_off >= REGION_BYTES);
    assign i_idx   = i_off[AW+1:2];
    assign d_idx   = d_off[AW+1:2] + HALF;
    assign acc_fault = (gnt_q == GNT_D) ? d_fault : i_fault;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;

    always_comb begin
        if (i_req && d_req) gnt_sel = last_d_q ? GNT_I : GNT_D;
        else if (d_req)     gnt_sel = GNT_D;
        else                gnt_sel = GNT_I;
        last_d_d = last_d_q;
        if (state_q == IDLE && (i_req || d_req)) last_d_d = (gnt_sel == GNT_D);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_q <= 1'b0;
        else        last_d_q <= last_d_d;
    end
`else
    always_comb begin
        gnt_sel = d_req ? GNT_D : GNT_I;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_NONE;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_err     = 1'b0;
        d_err     = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = GNT_NONE;
                err_d = 1'b0;
                if (i_req || d_req) begin
                    gnt_d   = gnt_sel;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                err_d   = acc_fault;
                state_d = RESP;
                if (!acc_fault) begin
                    if (gnt_q == GNT_D) begin
                        mem_addr  = d_idx;
                        mem_we    = d_we;
                        mem_wdata = d_wdata;
                    end else begin
                        mem_addr = i_idx;
                    end
                end
                // Faulted accesses still complete, but report zero data.
                if (gnt_q == GNT_D) d_rdata_d = acc_fault ? '0 : mem_rdata;
                else                i_rdata_d = acc_fault ? '0 : mem_rdata;
            end
            RESP: begin
                i_ready = (gnt_q == GNT_I);
                d_ready = (gnt_q == GNT_D);
                i_err   = (gnt_q == GNT_I) && err_q;
                d_err   = (gnt_q == GNT_D) && err_q;
                gnt_d   = GNT_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Controls access to a single-port unified word memory shared by the instruction-fetch port and the load/store data port of the core.
- Arbitrates between the two requesters, translates byte addresses into word indices, and range/alignment-checks each access.
- Sequences every access through a fixed 3-state handshake.
- Sits between the fetch/LSU logic and the memory array: combinational read, synchronous write on clk.

Parameters:
- DATA_WIDTH, 32, data and address width in bits.
- DEPTH, 1024, total memory words; power of two.
- TEXT_BASE, 32'h0040_0000, byte base of the text region; maps to words [0, DEPTH/2).
- DATA_BASE, 32'h1001_0000, byte base of the data region; maps to words [DEPTH/2, DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  DATA_WIDTH  fetch byte address; stable while i_req is high.
- i_rdata  out  DATA_WIDTH  fetched word; valid while i_ready is high.
- i_ready  out  1  one-cycle completion pulse, fetch port.
- i_err  out  1  fetch fault, qualified by i_ready.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  DATA_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; valid while d_ready is high.
- d_ready  out  1  one-cycle completion pulse, data port.
- d_err  out  1  data fault, qualified by d_ready.
- mem_addr  out  $clog2(DEPTH)  word index to the memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state = IDLE; all outputs 0; grant register = none; last-grant = instruction.
  - Asserting reset mid-access aborts the access.
  - No mem_we pulse may be produced after rst_n falls.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE; mem_addr = 0, mem_we = 0.
  - Any request: latch the grant (arbitration below), go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr with the translated index of the granted port.
  - mem_we = d_we, only for a legal data grant; mem_wdata = d_wdata.
  - At the clock edge, register mem_rdata into the granted port's rdata.
  - Go to RESP.
- RESP (1 cycle): assert the granted port's ready (and err if faulted), then go to IDLE unconditionally.
  - Requests are never re-arbitrated in RESP.
- Timing: request seen high in cycle 0 gives ready in cycle 2. Peak throughput is one access per 3 cycles.
- rdata registers hold their value until that port's next completion. A faulted access sets rdata = 0.
- Address translation:
  - Instruction index = (i_addr - TEXT_BASE) >> 2.
  - Data index = ((d_addr - DATA_BASE) >> 2) + DEPTH/2.
  - Subtraction is DATA_WIDTH-bit modular; the index is the low $clog2(DEPTH) bits after range check.
- Faults:
  - Fault if addr[1:0] != 0, or addr < base, or addr >= base + 2*DEPTH (region size DEPTH/2 words).
  - A faulted access still walks ACCESS and RESP.
  - In ACCESS it forces mem_we = 0 and mem_addr = 0; in RESP it raises err together with ready.
- Arbitration (default build): fixed priority, data over instruction.
  - If both requests are high in IDLE, the data port wins.
  - The fetch port is served on the next IDLE visit if it is still requesting.
- Requester protocol:
  - req, addr, we and wdata stay stable from assertion through the ready cycle.
  - Dropping req before ready is illegal; the block still completes the granted access and pulses ready.
- Only one ready is high in any cycle; i_ready and d_ready are mutually exclusive.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the port not granted last.
  - The last-grant register updates on entry to ACCESS and resets to instruction, so the first contended grant goes to data.
- Undefined: fixed data-over-instruction priority; no last-grant register is synthesised.

Test Plan:
- Reset then fetch: mem[0] = 32'h2008_0005; i_req = 1, i_addr = 32'h0040_0000 -> mem_addr = 0 in cycle 1; i_ready = 1 and i_rdata = 32'h2008_0005 in cycle 2; i_err = 0.
- Store then load: d_we = 1, d_addr = 32'h1001_0004, d_wdata = 32'hDEAD_BEEF -> mem_we = 1 for exactly one cycle at mem_addr = 513. A following load from the same address -> d_rdata = 32'hDEAD_BEEF with d_ready.
- Contention: i_req and d_req rise in the same cycle. Default build -> d_ready in cycle 2, i_ready in cycle 5. With MEM_ARB_RR_EN, a second simultaneous pair -> instruction served first.
- Faults:
  - i_addr = 32'h0040_0002 -> i_err = 1 and i_rdata = 0 with i_ready.
  - d_addr = 32'h0FFF_FFFC with d_we = 1 -> d_err = 1, mem_we never asserted.
  - d_addr = 32'h1001_0800 (= DATA_BASE + 2*DEPTH) -> d_err = 1.
- Reset mid-op: store granted; rst_n low during ACCESS -> mem_we drops immediately; after release, state is IDLE, no ready pulse, all outputs 0.
- Back-to-back: d_req held with two consecutive loads -> d_ready pulses exactly every 3 cycles, never in adjacent cycles.
